vec_magnitude_seq: RTL and testbench

Sequential vector-magnitude engine. Computes mag = sqrt(x^2 + y^2) for unsigned W-bit operands.
- Squares are formed with a shift-add multiplier.
- The root is extracted with a restoring bit-pair (digit-by-digit) algorithm.
- Rounding mode is selectable: floor or round-to-nearest.
- A start/busy/done handshake drives the block, and the sum of squares is exposed for debug.
- It is the parametrised successor of the team's fixed 8-bit hypotenuse datapath and sits behind the tile I/O wrapper.

---
 rtl/vec_magnitude_seq.sv | 174 +++++++++++++++++
 tb/tb_vec_magnitude_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_magnitude_seq.sv
// vec_magnitude_seq: sequential sqrt(x^2 + y^2) engine.
// Squares are built with a shift-add multiplier (one partial product per
// cycle), then the root is extracted one bit per cycle with a restoring
// bit-pair algorithm. A start/busy/done handshake drives the block and the
// sum of squares is kept visible for debug.

module vec_magnitude_seq #(
    parameter int W     = 8,   // operand width, 2..16
    parameter int ROUND = 0    // 0 = floor, 1 = round-to-nearest
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [W:0]     mag,
    output logic [2*W:0]   sumsq
);

    localparam int AW = 2 * W;          // width of one square
    localparam int SW = 2 * W + 2;      // root-extraction working width
    localparam int MW = W + 1;          // result width
    localparam int CW = $clog2(W + 2);  // step counter width (counts up to W)

    localparam logic [CW-1:0] MUL_LAST  = CW'(W - 1);
    localparam logic [CW-1:0] SQRT_LAST = CW'(W);

    typedef enum logic [2:0] {
        IDLE,
        SQX,
        SQY,
        SQRT,
        FIN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // xr / yr double as the multiplier shift registers: their LSB selects
    // whether the current shifted multiplicand is accumulated.
    logic [W-1:0]    xr;
    logic [W-1:0]    yr;
    logic [AW-1:0]   mcand;
    logic [AW-1:0]   accx;
    logic [AW-1:0]   accy;
    logic [2*W:0]    s;

    logic [SW-1:0]   rem;
    logic [SW-1:0]   root;
    logic [SW-1:0]   bitm;

    logic [AW-1:0]   accx_next;
    logic [AW-1:0]   accy_next;
    logic [2*W:0]    sum_sq;
    logic [SW-1:0]   trial;
    logic            round_up;

    // Next-step datapath values: partial-product adds, final sum, root trial and rounding decision.
    always_comb begin
        accx_next = accx;
        accy_next = accy;
        if (xr[0]) begin
            accx_next = accx + mcand;
        end
        if (yr[0]) begin
            accy_next = accy + mcand;
        end
        sum_sq   = {1'b0, accx} + {1'b0, accy_next};
        trial    = root + bitm;
        round_up = (ROUND == 1) && (rem > root);
    end

    // Control FSM and datapath registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            xr    <= '0;
            yr    <= '0;
            mcand <= '0;
            accx  <= '0;
            accy  <= '0;
            s     <= '0;
            rem   <= '0;
            root  <= '0;
            bitm  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            mag   <= '0;
            sumsq <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= x;
                        yr    <= y;
                        mcand <= {{W{1'b0}}, x};
                        accx  <= '0;
                        accy  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SQX;
                    end
                end

                SQX: begin
                    accx <= accx_next;
                    if (cnt == MUL_LAST) begin
                        mcand <= {{W{1'b0}}, yr};
                        xr    <= '0;
                        cnt   <= '0;
                        state <= SQY;
                    end else begin
                        mcand <= mcand << 1;
                        xr    <= xr >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end

                SQY: begin
                    accy <= accy_next;
                    if (cnt == MUL_LAST) begin
                        s     <= sum_sq;
                        rem   <= {1'b0, sum_sq};
                        root  <= '0;
                        bitm  <= {2'b01, {AW{1'b0}}};
                        yr    <= '0;
                        cnt   <= '0;
                        state <= SQRT;
                    end else begin
                        mcand <= mcand << 1;
                        yr    <= yr >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end

                SQRT: begin
                    if (rem >= trial) begin
                        rem  <= rem - trial;
                        root <= (root >> 1) + bitm;
                    end else begin
                        root <= root >> 1;
                    end
                    bitm <= bitm >> 2;
                    if (cnt == SQRT_LAST) begin
                        cnt   <= '0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                FIN: begin
                    mag   <= root[W:0] + MW'(round_up);
                    sumsq <= s;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_magnitude_seq.sv
// tb_vec_magnitude_seq: directed checks of vec_magnitude_seq in floor and
// round modes at W=8 plus a W=4 round-mode instance, followed by random
// operand pairs checked against an integer square-root model.

module tb_vec_magnitude_seq;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;

    logic        busy0, done0;
    logic [8:0]  mag0;
    logic [16:0] sumsq0;
    logic        busy1, done1;
    logic [8:0]  mag1;
    logic [16:0] sumsq1;
    logic        busy4, done4;
    logic [4:0]  mag4;
    logic [8:0]  sumsq4;

    int total;
    int bad;

    vec_magnitude_seq #(.W(8), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .x(x), .y(y),
        .busy(busy0), .done(done0), .mag(mag0), .sumsq(sumsq0)
    );

    vec_magnitude_seq #(.W(8), .ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .x(x), .y(y),
        .busy(busy1), .done(done1), .mag(mag1), .sumsq(sumsq1)
    );

    vec_magnitude_seq #(.W(4), .ROUND(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .x(x[3:0]), .y(y[3:0]),
        .busy(busy4), .done(done4), .mag(mag4), .sumsq(sumsq4)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference integer square root, found by linear search.
    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present operands with a one-cycle start pulse; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] xa, input logic [7:0] ya);
        x     = xa;
        y     = ya;
        start = 1'b1;
        step_cycle();
        start = 1'b0;
    endtask

    // Count cycles until the selected instance raises done; -1 on timeout.
    task automatic wait_done(input int sel, output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            step_cycle();
            if ((sel == 4) ? done4 : done0) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int extra;
        int s_ref;
        int r_ref;
        int rr_ref;
        logic [7:0] rx;
        logic [7:0] ry;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;

        // Reset state
        repeat (3) step_cycle();
        checkOutput("rst_busy",  32'(busy0),  0);
        checkOutput("rst_done",  32'(done0),  0);
        checkOutput("rst_mag",   32'(mag0),   0);
        checkOutput("rst_sumsq", 32'(sumsq0), 0);
        rst_n = 1'b1;
        step_cycle();

        // 3,4 -> 5, latency and single-cycle done
        applyStimulus(8'd3, 8'd4);
        checkOutput("b34_busy", 32'(busy0), 1);
        wait_done(0, lat);
        checkOutput("b34_lat",   32'(lat),    26);
        checkOutput("b34_mag0",  32'(mag0),   5);
        checkOutput("b34_mag1",  32'(mag1),   5);
        checkOutput("b34_sumsq", 32'(sumsq0), 25);
        checkOutput("b34_busyf", 32'(busy0),  0);
        step_cycle();
        checkOutput("b34_done_pulse", 32'(done0), 0);
        checkOutput("b34_mag_hold",   32'(mag0),  5);

        // Max operands
        applyStimulus(8'd255, 8'd255);
        wait_done(0, lat);
        checkOutput("max_lat",   32'(lat),    26);
        checkOutput("max_sumsq", 32'(sumsq0), 130050);
        checkOutput("max_mag0",  32'(mag0),   360);
        checkOutput("max_mag1",  32'(mag1),   361);

        // 7,7 -> 98 rounds up
        applyStimulus(8'd7, 8'd7);
        wait_done(0, lat);
        checkOutput("s77_sumsq", 32'(sumsq1), 98);
        checkOutput("s77_mag0",  32'(mag0),   9);
        checkOutput("s77_mag1",  32'(mag1),   10);

        // Zero and unit operands keep full latency
        applyStimulus(8'd0, 8'd0);
        wait_done(0, lat);
        checkOutput("zero_lat",  32'(lat),  26);
        checkOutput("zero_mag0", 32'(mag0), 0);
        checkOutput("zero_mag1", 32'(mag1), 0);
        applyStimulus(8'd1, 8'd1);
        wait_done(0, lat);
        checkOutput("one_lat",   32'(lat),    26);
        checkOutput("one_sumsq", 32'(sumsq0), 2);
        checkOutput("one_mag0",  32'(mag0),   1);
        checkOutput("one_mag1",  32'(mag1),   1);

        // Start while busy and operand changes are ignored
        applyStimulus(8'd5, 8'd12);
        repeat (9) step_cycle();
        x     = 8'd1;
        y     = 8'd1;
        start = 1'b1;
        step_cycle();
        start = 1'b0;
        wait_done(0, lat);
        checkOutput("ign_lat",   32'(lat),    16);
        checkOutput("ign_mag",   32'(mag0),   13);
        checkOutput("ign_sumsq", 32'(sumsq0), 169);
        extra = 0;
        repeat (40) begin
            step_cycle();
            if (done0) extra++;
        end
        checkOutput("ign_no_second_done", 32'(extra), 0);

        // ena low for 7 cycles during SQRT stretches latency
        applyStimulus(8'd6, 8'd8);
        repeat (17) step_cycle();
        ena = 1'b0;
        repeat (7) step_cycle();
        checkOutput("ena_busy_hold", 32'(busy0), 1);
        checkOutput("ena_done_hold", 32'(done0), 0);
        ena = 1'b1;
        wait_done(0, lat);
        checkOutput("ena_lat",   32'(lat),    9);
        checkOutput("ena_mag",   32'(mag0),   10);
        checkOutput("ena_sumsq", 32'(sumsq0), 100);

        // Reset mid-operation aborts
        applyStimulus(8'd9, 8'd40);
        repeat (15) step_cycle();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mag",   32'(mag0),   0);
        checkOutput("abort_busy",  32'(busy0),  0);
        checkOutput("abort_done",  32'(done0),  0);
        checkOutput("abort_sumsq", 32'(sumsq0), 0);
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            step_cycle();
            if (done0) extra++;
        end
        checkOutput("abort_no_done", 32'(extra), 0);
        applyStimulus(8'd8, 8'd15);
        wait_done(0, lat);
        checkOutput("post_lat",   32'(lat),    26);
        checkOutput("post_mag",   32'(mag0),   17);
        checkOutput("post_sumsq", 32'(sumsq0), 289);

        // Back-to-back with start held; accepted in the done cycle
        x     = 8'd3;
        y     = 8'd4;
        start = 1'b1;
        step_cycle();
        x     = 8'd5;
        y     = 8'd12;
        wait_done(0, lat);
        checkOutput("b2b_lat1", 32'(lat),  26);
        checkOutput("b2b_mag1", 32'(mag0), 5);
        step_cycle();
        checkOutput("b2b_busy", 32'(busy0), 1);
        checkOutput("b2b_done", 32'(done0), 0);
        start = 1'b0;
        wait_done(0, lat);
        checkOutput("b2b_lat2", 32'(lat),  26);
        checkOutput("b2b_mag2", 32'(mag0), 13);

        // W=4 round mode, 15,15
        applyStimulus(8'd15, 8'd15);
        wait_done(4, lat);
        checkOutput("w4_lat",   32'(lat),    14);
        checkOutput("w4_sumsq", 32'(sumsq4), 450);
        checkOutput("w4_mag",   32'(mag4),   21);
        wait_done(0, lat);
        checkOutput("w8_1515_lat", 32'(lat),  12);
        checkOutput("w8_1515_mag", 32'(mag0), 21);

        // Random pairs against the reference model, both modes
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            s_ref  = int'(rx) * int'(rx) + int'(ry) * int'(ry);
            r_ref  = isqrt(s_ref);
            rr_ref = ((s_ref - r_ref * r_ref) > r_ref) ? r_ref + 1 : r_ref;
            applyStimulus(rx, ry);
            wait_done(0, lat);
            checkOutput("rnd_sumsq", 32'(sumsq0), 32'(s_ref));
            checkOutput("rnd_mag0",  32'(mag0),   32'(r_ref));
            checkOutput("rnd_mag1",  32'(mag1),   32'(rr_ref));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
